// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I multicycle core.
// Latency: ALU/LUI/JAL 4 cycles, branch 3, SW 4, LW 5 with zero-wait memory; each memory wait adds a cycle.
// Backpressure: mem_req is held until mem_ready; a wait running to 2**TIMEOUT_W-1 sets mem_timeout and halts.
// Optional: define RV_CTRL_ILLEGAL_TRAP_EN to add a sticky 'illegal' output that halts on unsupported encodings.
module rv_multicycle_ctrl #(
    parameter int ALU_OP_W  = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                alu_zero,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_src,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                alu_src_b,
    output logic [1:0]          wd_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          state,
    output logic                retire,
    output logic                mem_timeout
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Instruction classes; C_NOP covers every encoding the core does not support.
    typedef enum logic [2:0] {
        C_ALU_R, C_ALU_I, C_LUI, C_LW, C_SW, C_BR, C_JAL, C_NOP
    } class_e;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 cnt_last;
    logic                 tmo_q, tmo_d;
    class_e               cls;
    logic [6:0]           opcode;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [3:0]           exec_op;
    logic                 exec_srcb;
    logic                 br_taken;
    logic [3:0]           alu_op4;

    // Register/immediate fields are consumed by the datapath, not by this controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Wait counter reaches all-ones on this cycle's increment: that is the timeout point.
    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_last = &cnt_inc;

    // Branch condition from the ALU zero flag: BNE/BLT/BLTU take on non-zero, BEQ/BGE/BGEU on zero.
    assign br_taken = alu_zero ^ (f3[0] ^ f3[2]);

    // R-type/I-type funct3 to ALU operation; alt selects SUB or SRA.
    function automatic logic [3:0] f3_op(input logic [2:0] fn, input logic alt);
        logic [3:0] op;
        case (fn)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    // Classify the instruction; any unsupported opcode/f3/f7 combination falls to C_NOP.
    always_comb begin
        cls = C_NOP;
        case (opcode)
            7'b0110011: begin
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    cls = C_ALU_R;
            end
            7'b0010011: begin
                if (f3 == 3'b001) begin
                    if (f7 == 7'b0000000) cls = C_ALU_I;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0000000 || f7 == 7'b0100000) cls = C_ALU_I;
                end else begin
                    cls = C_ALU_I;
                end
            end
            7'b0110111: cls = C_LUI;
            7'b0000011: if (f3 == 3'b010) cls = C_LW;
            7'b0100011: if (f3 == 3'b010) cls = C_SW;
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) cls = C_BR;
            7'b1101111: cls = C_JAL;
            default:    cls = C_NOP;
        endcase
    end

    // ALU controls per class; only presented in EXEC, the datapath latches the result.
    always_comb begin
        exec_op   = OP_ADD;
        exec_srcb = 1'b0;
        case (cls)
            C_ALU_R: exec_op = f3_op(f3, f7[5]);
            C_ALU_I: begin
                exec_op   = f3_op(f3, (f3 == 3'b101) && f7[5]);
                exec_srcb = 1'b1;
            end
            C_LW, C_SW: begin
                exec_op   = OP_ADD;
                exec_srcb = 1'b1;
            end
            C_BR: begin
                case (f3[2:1])
                    2'b00:   exec_op = OP_SUB;
                    2'b10:   exec_op = OP_SLT;
                    default: exec_op = OP_SLTU;
                endcase
            end
            default: exec_op = OP_ADD;
        endcase
    end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    logic ill_q, ill_d;
`endif

    // Next-state and strobe decode; everything is forced low while rst is held.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        tmo_d        = tmo_q;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        ill_d        = ill_q;
`endif
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        reg_write    = 1'b0;
        alu_src_b    = 1'b0;
        wd_src       = 2'd0;
        alu_op4      = OP_ADD;
        retire       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (cnt_last) begin
                    tmo_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                if (cls == C_NOP) begin
                    ill_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                alu_op4   = exec_op;
                alu_src_b = exec_srcb;
                case (cls)
                    C_ALU_R, C_ALU_I, C_LUI: state_d = S_WB;
                    C_LW, C_SW:              state_d = S_MEM;
                    C_BR: begin
                        if (br_taken) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        state_d  = S_WB;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = (cls == C_SW);
                if (mem_ready) begin
                    if (cls == C_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_last) begin
                    tmo_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                case (cls)
                    C_LW:    wd_src = 2'd1;
                    C_LUI:   wd_src = 2'd2;
                    C_JAL:   wd_src = 2'd3;
                    default: wd_src = 2'd0;
                endcase
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_src = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 2'd0;
            reg_write    = 1'b0;
            alu_src_b    = 1'b0;
            wd_src       = 2'd0;
            alu_op4      = OP_ADD;
            retire       = 1'b0;
        end
        alu_op = ALU_OP_W'(alu_op4);
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-instruction flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end

    assign illegal = rst ? 1'b0 : ill_q;
`endif

    assign state       = rst ? 3'd0 : state_q;
    assign mem_timeout = rst ? 1'b0 : tmo_q;

endmodule
